// File: rtl/zrb_sync_fifo_lvl_if.sv
// zrb_sync_fifo_lvl_if: request, data and status bundle for the level-aware sync fifo
interface zrb_sync_fifo_lvl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );
  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/zrb_sync_fifo_lvl.sv
// zrb_sync_fifo_lvl: single-clock fifo with fill count, level thresholds, sticky errors, flush and selectable read mode
module zrb_sync_fifo_lvl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 1,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 3
) (
  input logic                 clk,
  input logic                 reset,
  zrb_sync_fifo_lvl_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, cnt;
  logic [DATA_WIDTH-1:0] dout_q, head;
  logic                  rv_q, ovf_q, udf_q, full, empty, we, re, clr;
  assign full  = cnt == DEPTH_C;
  assign empty = cnt == '0;
  assign clr   = reset | bus.flush;
  assign we    = bus.wr_en & ~full & ~clr;
  assign re    = bus.rd_en & ~empty & ~clr;
  assign head  = mem[rd_ptr[ADDR_WIDTH-1:0]];
  // storage array, deliberately left uninitialised on reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
  end
  // pointers, count, sticky errors and the registered read port
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      rv_q   <= 1'b0;
      if (reset) dout_q <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (ADDR_WIDTH+1)'(we) - (ADDR_WIDTH+1)'(re);
      if (bus.wr_en & full) ovf_q <= 1'b1;
      if (bus.rd_en & empty) udf_q <= 1'b1;
      rv_q <= re;
      if (re) dout_q <= head;
    end
  end
  assign bus.data_out     = (FWFT != 0) ? head : dout_q;
  assign bus.rd_valid     = (FWFT != 0) ? ~empty : rv_q;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = cnt >= AF_C;
  assign bus.almost_empty = cnt <= AE_C;
  assign bus.fill_count   = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_zrb_sync_fifo_lvl.sv
// tb_zrb_sync_fifo_lvl: directed checks of both read modes of the level-aware fifo
module tb_zrb_sync_fifo_lvl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  zrb_sync_fifo_lvl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) f1 ();
  zrb_sync_fifo_lvl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) f0 ();
  zrb_sync_fifo_lvl #(.FWFT(1)) dut1 (.clk(clk), .reset(reset), .bus(f1));
  zrb_sync_fifo_lvl #(.FWFT(0)) dut0 (.clk(clk), .reset(reset), .bus(f0));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic put1(input logic [7:0] d);
    f1.wr_en = 1'b1;
    f1.data_in = d;
    tick();
    f1.wr_en = 1'b0;
  endtask
  task automatic put0(input logic [7:0] d);
    f0.wr_en = 1'b1;
    f0.data_in = d;
    tick();
    f0.wr_en = 1'b0;
  endtask
  task automatic flush1();
    f1.flush = 1'b1;
    tick();
    f1.flush = 1'b0;
  endtask
  initial begin
    f1.flush = 0; f1.wr_en = 0; f1.rd_en = 0; f1.data_in = 0;
    f0.flush = 0; f0.wr_en = 0; f0.rd_en = 0; f0.data_in = 0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_fill", 32'(f1.fill_count), 0);
    chk("rst_empty", 32'(f1.fifo_empty), 1);
    chk("rst_ae", 32'(f1.almost_empty), 1);
    chk("rst_full", 32'(f1.fifo_full), 0);
    chk("rst_af", 32'(f1.almost_full), 0);
    chk("rst_ovf", 32'(f1.overflow), 0);
    chk("rst_udf", 32'(f1.underflow), 0);
    chk("rst_rv", 32'(f1.rd_valid), 0);
    for (int i = 1; i <= 16; i++) begin
      put1(8'(i));
      chk("wr_fill", 32'(f1.fill_count), 32'(i));
      chk("wr_af", 32'(f1.almost_full), 32'(i >= 12));
      chk("wr_full", 32'(f1.fifo_full), 32'(i == 16));
      chk("wr_ae", 32'(f1.almost_empty), 32'(i <= 3));
    end
    chk("pre_ovf", 32'(f1.overflow), 0);
    put1(8'hFF);
    chk("ovf_fill", 32'(f1.fill_count), 16);
    chk("ovf_flag", 32'(f1.overflow), 1);
    for (int i = 1; i <= 16; i++) begin
      chk("rd_data", 32'(f1.data_out), 32'(i));
      f1.rd_en = 1'b1;
      tick();
      f1.rd_en = 1'b0;
      chk("rd_fill", 32'(f1.fill_count), 32'(16 - i));
      chk("rd_ae", 32'(f1.almost_empty), 32'(16 - i <= 3));
      chk("rd_empty", 32'(f1.fifo_empty), 32'(i == 16));
      chk("rd_valid", 32'(f1.rd_valid), 32'(i != 16));
    end
    chk("pre_udf", 32'(f1.underflow), 0);
    f1.rd_en = 1'b1;
    tick();
    f1.rd_en = 1'b0;
    chk("udf_fill", 32'(f1.fill_count), 0);
    chk("udf_flag", 32'(f1.underflow), 1);
    chk("ovf_sticky", 32'(f1.overflow), 1);
    flush1();
    chk("fl_ovf", 32'(f1.overflow), 0);
    chk("fl_udf", 32'(f1.underflow), 0);
    for (int i = 0; i < 5; i++) put1(8'(8'h20 + i));
    f1.wr_en = 1'b1; f1.rd_en = 1'b1; f1.data_in = 8'h25;
    tick();
    f1.wr_en = 1'b0; f1.rd_en = 1'b0;
    chk("sim5_fill", 32'(f1.fill_count), 5);
    for (int i = 1; i <= 5; i++) begin
      chk("sim5_order", 32'(f1.data_out), 32'(8'h20 + i));
      f1.rd_en = 1'b1;
      tick();
      f1.rd_en = 1'b0;
    end
    chk("sim5_drained", 32'(f1.fill_count), 0);
    for (int i = 0; i < 16; i++) put1(8'(8'h30 + i));
    f1.wr_en = 1'b1; f1.rd_en = 1'b1; f1.data_in = 8'hEE;
    tick();
    f1.wr_en = 1'b0; f1.rd_en = 1'b0;
    chk("sim16_fill", 32'(f1.fill_count), 15);
    chk("sim16_ovf", 32'(f1.overflow), 1);
    chk("sim16_head", 32'(f1.data_out), 32'h31);
    flush1();
    f1.wr_en = 1'b1; f1.rd_en = 1'b1; f1.data_in = 8'h55;
    tick();
    f1.wr_en = 1'b0; f1.rd_en = 1'b0;
    chk("sim0_fill", 32'(f1.fill_count), 1);
    chk("sim0_udf", 32'(f1.underflow), 1);
    chk("sim0_ovf", 32'(f1.overflow), 0);
    chk("sim0_head", 32'(f1.data_out), 32'h55);
    flush1();
    for (int i = 0; i < 3; i++) put1(8'(i));
    for (int k = 3; k < 43; k++) begin
      chk("wrap_head", 32'(f1.data_out), 32'(k - 3));
      f1.wr_en = 1'b1; f1.rd_en = 1'b1; f1.data_in = 8'(k);
      tick();
      f1.wr_en = 1'b0; f1.rd_en = 1'b0;
      chk("wrap_fill", 32'(f1.fill_count), 3);
      chk("wrap_flags", 32'({f1.almost_empty, f1.fifo_empty, f1.fifo_full, f1.almost_full, f1.overflow, f1.underflow}), 32'b100000);
    end
    for (int pass = 0; pass < 2; pass++) begin
      flush1();
      f1.rd_en = 1'b1;
      tick();
      f1.rd_en = 1'b0;
      for (int i = 0; i < 7; i++) put1(8'(8'h60 + i));
      chk("clr_pre_fill", 32'(f1.fill_count), 7);
      chk("clr_pre_udf", 32'(f1.underflow), 1);
      f1.wr_en = 1'b1; f1.data_in = 8'h77;
      if (pass == 0) f1.flush = 1'b1; else reset = 1'b1;
      tick();
      f1.wr_en = 1'b0; f1.flush = 1'b0; reset = 1'b0;
      chk("clr_fill", 32'(f1.fill_count), 0);
      chk("clr_empty", 32'(f1.fifo_empty), 1);
      chk("clr_errs", 32'({f1.overflow, f1.underflow}), 0);
      put1(8'h88);
      chk("clr_after_fill", 32'(f1.fill_count), 1);
      chk("clr_after_head", 32'(f1.data_out), 32'h88);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    put0(8'hA5);
    chk("r0_wr_rv", 32'(f0.rd_valid), 0);
    chk("r0_wr_dout", 32'(f0.data_out), 0);
    chk("r0_wr_fill", 32'(f0.fill_count), 1);
    f0.rd_en = 1'b1;
    tick();
    f0.rd_en = 1'b0;
    chk("r0_rv", 32'(f0.rd_valid), 1);
    chk("r0_dout", 32'(f0.data_out), 32'hA5);
    tick();
    chk("r0_rv_drop", 32'(f0.rd_valid), 0);
    chk("r0_hold", 32'(f0.data_out), 32'hA5);
    put0(8'h11); put0(8'h22); put0(8'h33);
    f0.rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("r0_b2b_rv", 32'(f0.rd_valid), 1);
      chk("r0_b2b_dout", 32'(f0.data_out), 32'(8'h11 * i));
    end
    f0.rd_en = 1'b0;
    tick();
    chk("r0_b2b_end_rv", 32'(f0.rd_valid), 0);
    chk("r0_b2b_end_dout", 32'(f0.data_out), 32'h33);
    put0(8'h44);
    f0.flush = 1'b1; f0.wr_en = 1'b1; f0.data_in = 8'h77;
    tick();
    f0.flush = 1'b0; f0.wr_en = 1'b0;
    chk("r0_fl_fill", 32'(f0.fill_count), 0);
    chk("r0_fl_dout", 32'(f0.data_out), 32'h33);
    for (int i = 0; i < 7; i++) put0(8'(8'h60 + i));
    f0.wr_en = 1'b1; f0.data_in = 8'h77; reset = 1'b1;
    tick();
    f0.wr_en = 1'b0; reset = 1'b0;
    chk("r0_rst_fill", 32'(f0.fill_count), 0);
    chk("r0_rst_empty", 32'(f0.fifo_empty), 1);
    chk("r0_rst_dout", 32'(f0.data_out), 0);
    chk("r0_rst_errs", 32'({f0.overflow, f0.underflow, f0.rd_valid}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
